// File: rtl/sdram_wr_burst_ctrl.sv
// sdram_wr_burst_ctrl: drains a show-ahead write FIFO into fixed-length SDRAM
// write bursts, walking the write address through a circular buffer region.
// A level flush input lets a final partial burst go out while idle.
module sdram_wr_burst_ctrl #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned USEDW_WIDTH = 10,
  parameter int unsigned ADDR_WIDTH  = 22,
  parameter int unsigned BURST_LEN   = 256,
  parameter int unsigned ADDR_BASE   = 0,
  parameter int unsigned ADDR_END    = 32'h0008_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   flush,
  input  logic [DATA_WIDTH-1:0]  fifo_dout,
  input  logic                   fifo_empty,
  input  logic [USEDW_WIDTH-1:0] fifo_rdusedw,
  output logic                   fifo_re,
  output logic                   wr_req,
  input  logic                   wr_ack,
  output logic [ADDR_WIDTH-1:0]  wr_addr,
  output logic [USEDW_WIDTH-1:0] wr_len,
  input  logic                   wr_data_req,
  output logic [DATA_WIDTH-1:0]  wr_data,
  input  logic                   wr_done,
  output logic                   busy,
  output logic                   wrap,
  output logic                   underflow_err
);

  localparam logic [USEDW_WIDTH-1:0] BURST_LEN_L = USEDW_WIDTH'(BURST_LEN);
  localparam logic [ADDR_WIDTH-1:0]  ADDR_BASE_L = ADDR_WIDTH'(ADDR_BASE);
  // One extra bit so base + length can never wrap around before the compare.
  localparam logic [ADDR_WIDTH:0]    ADDR_END_X  = (ADDR_WIDTH + 1)'(ADDR_END);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [USEDW_WIDTH-1:0] beat_q, beat_d;
  logic [USEDW_WIDTH-1:0] wr_len_q, wr_len_d;
  logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
  logic                   wr_req_q, wr_req_d;
  logic                   busy_q, busy_d;
  logic                   wrap_q, wrap_d;
  logic                   underflow_q, underflow_d;
  logic [ADDR_WIDTH:0]    next_addr;
  logic                   in_data;

  // Partial bursts never exceed a normal burst length.
  function automatic logic [USEDW_WIDTH-1:0] clamp_len(input logic [USEDW_WIDTH-1:0] avail);
    return (avail < BURST_LEN_L) ? avail : BURST_LEN_L;
  endfunction

  // Data path is a zero-latency pass-through; pops are suppressed during reset
  // and whenever the FIFO is empty (the controller then receives zeros).
  assign in_data   = (state_q == S_DATA);
  assign fifo_re   = in_data & wr_data_req & ~fifo_empty & ~rst;
  assign wr_data   = (in_data & ~fifo_empty) ? fifo_dout : '0;
  assign next_addr = {1'b0, wr_addr_q} + (ADDR_WIDTH + 1)'(wr_len_q);

  assign wr_req        = wr_req_q;
  assign wr_addr       = wr_addr_q;
  assign wr_len        = wr_len_q;
  assign busy          = busy_q;
  assign wrap          = wrap_q;
  assign underflow_err = underflow_q;

  // Next-state and next-output computation for the burst sequencer.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    wr_len_d    = wr_len_q;
    wr_addr_d   = wr_addr_q;
    wr_req_d    = wr_req_q;
    wrap_d      = 1'b0;
    underflow_d = underflow_q;
    case (state_q)
      S_IDLE: begin
        if (enable && (fifo_rdusedw >= BURST_LEN_L)) begin
          wr_len_d = BURST_LEN_L;
          wr_req_d = 1'b1;
          state_d  = S_REQ;
        end else if (enable && flush && !fifo_empty) begin
          wr_len_d = clamp_len(fifo_rdusedw);
          wr_req_d = 1'b1;
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        if (wr_ack) begin
          wr_req_d = 1'b0;
          beat_d   = '0;
          state_d  = S_DATA;
        end
      end
      S_DATA: begin
        if (wr_data_req) begin
          beat_d = beat_q + USEDW_WIDTH'(1);
          if (fifo_empty) underflow_d = 1'b1;
          if (beat_q == (wr_len_q - USEDW_WIDTH'(1))) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (wr_done) begin
          if (next_addr >= ADDR_END_X) begin
            wr_addr_d = ADDR_BASE_L;
            wrap_d    = 1'b1;
          end else begin
            wr_addr_d = next_addr[ADDR_WIDTH-1:0];
          end
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Sequencer state and registered outputs; reset abandons any burst in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      beat_q      <= '0;
      wr_len_q    <= '0;
      wr_addr_q   <= ADDR_BASE_L;
      wr_req_q    <= 1'b0;
      busy_q      <= 1'b0;
      wrap_q      <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      wr_len_q    <= wr_len_d;
      wr_addr_q   <= wr_addr_d;
      wr_req_q    <= wr_req_d;
      busy_q      <= busy_d;
      wrap_q      <= wrap_d;
      underflow_q <= underflow_d;
    end
  end

endmodule

// File: tb/tb_sdram_wr_burst_ctrl.sv
// Bench for sdram_wr_burst_ctrl: show-ahead FIFO model, SDRAM write-port
// driver and a reference stream/address model.
module tb_sdram_wr_burst_ctrl;

  localparam int DW   = 16;
  localparam int UW   = 10;
  localparam int AW   = 22;
  localparam int BL   = 256;
  localparam int AEND = 512;

  logic          clk = 1'b0;
  logic          rst, enable, flush, fifo_empty, fifo_re;
  logic          wr_req, wr_ack, wr_data_req, wr_done, busy, wrap, underflow_err;
  logic [DW-1:0] fifo_dout, wr_data;
  logic [UW-1:0] fifo_rdusedw, wr_len;
  logic [AW-1:0] wr_addr;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [15:0] fq[$];
  logic [15:0] rq[$];
  int          bias = 0;
  logic [15:0] wval = 16'h0000;
  int          exp_addr = 0;
  logic        exp_uf = 1'b0;

  typedef struct {
    logic en;
    logic fl;
    int   n;
    logic req;
    int   len;
  } vec_t;
  vec_t vt[8];

  always #5 clk = ~clk;

  sdram_wr_burst_ctrl #(
    .DATA_WIDTH(DW), .USEDW_WIDTH(UW), .ADDR_WIDTH(AW),
    .BURST_LEN(BL), .ADDR_BASE(0), .ADDR_END(AEND)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush),
    .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rdusedw(fifo_rdusedw),
    .fifo_re(fifo_re), .wr_req(wr_req), .wr_ack(wr_ack), .wr_addr(wr_addr),
    .wr_len(wr_len), .wr_data_req(wr_data_req), .wr_data(wr_data),
    .wr_done(wr_done), .busy(busy), .wrap(wrap), .underflow_err(underflow_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fifo_sync();
    fifo_empty   = (fq.size() == 0);
    fifo_dout    = 16'hDEAD;
    if (fq.size() != 0) fifo_dout = fq[0];
    fifo_rdusedw = UW'(fq.size() + bias);
  endtask

  task automatic push(input int n);
    for (int i = 0; i < n; i++) begin
      fq.push_back(wval);
      rq.push_back(wval);
      wval = wval + 16'd1;
    end
    fifo_sync();
  endtask

  task automatic clear_q();
    fq.delete();
    rq.delete();
    fifo_sync();
  endtask

  // Advance one clock; the FIFO model pops whatever the DUT asked for at the edge.
  task automatic tick();
    logic p;
    #2;
    p = fifo_re;
    @(posedge clk);
    #1;
    if (p === 1'b1 && fq.size() > 0) fq.delete(0);
    fifo_sync();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
    exp_addr = 0;
    exp_uf = 1'b0;
  endtask

  // gap: 0 continuous, 1 alternating 1-0-1, 2 random
  task automatic do_burst(input int len, input int ack_dly, input int gap,
                          input int done_dly, input bit drop);
    int cnt, beats, cyc, nxt;
    logic rq_bit, exp_pop, exp_wrap;
    cnt = 0; beats = 0; cyc = 0;
    while (wr_req !== 1'b1 && cnt < 12) begin
      tick();
      cnt++;
    end
    chk("req_seen", wr_req, 1);
    if (wr_req !== 1'b1) return;
    chk("wr_len", wr_len, len);
    chk("wr_addr_start", wr_addr, exp_addr);
    chk("busy_req", busy, 1);
    repeat (ack_dly) begin
      wr_data_req = 1'($urandom_range(0, 1));
      #1;
      chk("re_in_req", fifo_re, 0);
      tick();
      chk("req_hold", wr_req, 1);
    end
    wr_data_req = 1'b0;
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    chk("req_drop", wr_req, 0);
    if (drop) begin
      enable = 1'b0;
      flush = 1'b0;
    end
    while (beats < len && cyc < 4 * len + 20) begin
      if (gap == 0) rq_bit = 1'b1;
      else if (gap == 1) rq_bit = (cyc % 2 == 0);
      else rq_bit = 1'($urandom_range(0, 1));
      wr_data_req = rq_bit;
      #1;
      if (rq_bit) begin
        exp_pop = (rq.size() != 0);
        chk("fifo_re", fifo_re, exp_pop);
        chk("wr_data", wr_data, exp_pop ? 32'(rq[0]) : 32'd0);
        if (exp_pop) rq.delete(0);
        else exp_uf = 1'b1;
        beats++;
      end else begin
        chk("re_gap", fifo_re, 0);
      end
      tick();
      chk("underflow", underflow_err, exp_uf);
      cyc++;
    end
    chk("beats_done", beats, len);
    wr_data_req = 1'b0;
    chk("busy_done", busy, 1);
    repeat (done_dly) begin
      wr_data_req = 1'($urandom_range(0, 1));
      #1;
      chk("re_in_done", fifo_re, 0);
      tick();
      chk("busy_wait", busy, 1);
    end
    wr_data_req = 1'b0;
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    nxt = exp_addr + len;
    exp_wrap = (nxt >= AEND);
    exp_addr = exp_wrap ? 0 : nxt;
    chk("busy_idle", busy, 0);
    chk("addr_upd", wr_addr, exp_addr);
    chk("wrap", wrap, exp_wrap);
    tick();
    chk("wrap_clear", wrap, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, n, len;
    rst = 1'b1; enable = 1'b0; flush = 1'b0; wr_ack = 1'b0;
    wr_data_req = 1'b1; wr_done = 1'b0;
    fifo_sync();

    vt[0] = '{1'b0, 1'b0, 300, 1'b0, 0};
    vt[1] = '{1'b0, 1'b1, 10,  1'b0, 0};
    vt[2] = '{1'b1, 1'b0, 255, 1'b0, 0};
    vt[3] = '{1'b1, 1'b1, 0,   1'b0, 0};
    vt[4] = '{1'b1, 1'b1, 10,  1'b1, 10};
    vt[5] = '{1'b1, 1'b0, 256, 1'b1, 256};
    vt[6] = '{1'b1, 1'b1, 300, 1'b1, 256};
    vt[7] = '{1'b1, 1'b0, 257, 1'b1, 256};

    // Reset state
    tick(); tick();
    #1;
    chk("rst_no_pop", fifo_re, 0);
    chk("rst_addr", wr_addr, 0);
    chk("rst_req", wr_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_uf", underflow_err, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_len", wr_len, 0);
    rst = 1'b0;
    wr_data_req = 1'b0;

    // Start-condition table
    for (int i = 0; i < 8; i++) begin
      do_reset(1);
      clear_q();
      push(vt[i].n);
      enable = vt[i].en;
      flush = vt[i].fl;
      tick();
      chk("vec_req", wr_req, vt[i].req);
      chk("vec_busy", busy, vt[i].req);
      if (vt[i].req) chk("vec_len", wr_len, vt[i].len);
      enable = 1'b0;
      flush = 1'b0;
    end

    // Stray ack while idle is ignored
    do_reset(1);
    clear_q();
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    tick();
    chk("stray_ack_busy", busy, 0);

    // Full burst from 300 preloaded words
    wval = 16'h0000;
    push(300);
    enable = 1'b1;
    do_burst(256, 3, 0, 2, 0);
    chk("left_44", fq.size(), 44);
    repeat (4) begin
      tick();
      chk("no_second_req", wr_req, 0);
    end

    // Flush partial burst
    flush = 1'b1;
    do_burst(44, 1, 0, 2, 1);
    chk("flush_addr", wr_addr, 300);
    chk("flush_empty", fifo_empty, 1);
    chk("flush_idle", busy, 0);

    // Wrap across the 512-word region
    do_reset(1);
    clear_q();
    push(512);
    enable = 1'b1;
    do_burst(256, 2, 0, 1, 0);
    chk("turnaround", wr_req, 1);
    do_burst(256, 0, 0, 3, 1);
    chk("wrap_addr", wr_addr, 0);

    // Underflow: 255 words, fill count over-reported by one
    do_reset(1);
    clear_q();
    push(255);
    bias = 1;
    fifo_sync();
    enable = 1'b1;
    do_burst(256, 1, 0, 1, 1);
    bias = 0;
    fifo_sync();
    repeat (3) tick();
    chk("uf_sticky", underflow_err, 1);
    do_reset(1);
    chk("uf_cleared", underflow_err, 0);

    // Gapped data with enable dropped mid-burst
    clear_q();
    push(512);
    enable = 1'b1;
    do_burst(256, 1, 1, 1, 1);
    repeat (6) tick();
    chk("gap_no_req", wr_req, 0);
    chk("gap_idle", busy, 0);

    // Reset during DATA
    enable = 1'b1;
    cnt = 0;
    while (wr_req !== 1'b1 && cnt < 12) begin
      tick();
      cnt++;
    end
    chk("abort_req", wr_req, 1);
    chk("abort_addr0", wr_addr, 256);
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    enable = 1'b0;
    wr_data_req = 1'b1;
    repeat (5) tick();
    chk("abort_pops", fq.size(), 251);
    rst = 1'b1;
    #1;
    chk("abort_no_pop", fifo_re, 0);
    tick();
    rst = 1'b0;
    wr_data_req = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_req0", wr_req, 0);
    chk("abort_addr", wr_addr, 0);
    chk("abort_left", fq.size(), 251);
    tick();
    chk("abort_stay_idle", busy, 0);

    // Randomized bursts against the reference model
    do_reset(1);
    clear_q();
    for (int k = 0; k < 6; k++) begin
      n = $urandom_range(1, 400);
      push(n);
      if (rq.size() < BL) flush = 1'b1;
      len = (rq.size() < BL) ? rq.size() : BL;
      enable = 1'b1;
      do_burst(len, $urandom_range(0, 4), 2, $urandom_range(0, 3), 1);
      chk("rand_fifo_sync", fq.size(), rq.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
